// File: rtl/pcs_rx_block_lock_if.sv
// Gearbox-facing status/header inputs and lock/slip outputs of the 64b/66b RX block-lock controller.
interface pcs_rx_block_lock_if;
    logic [1:0] SGNL_OK;
    logic       hdr_vld_i;
    logic       sh_ok_i;
    logic       slip_o;
    logic       LOCK;
    logic       RXVALID;
    logic       hi_ber_o;

    modport master (
        output SGNL_OK, hdr_vld_i, sh_ok_i,
        input  slip_o, LOCK, RXVALID, hi_ber_o
    );

    modport slave (
        input  SGNL_OK, hdr_vld_i, sh_ok_i,
        output slip_o, LOCK, RXVALID, hi_ber_o
    );
endinterface

// File: rtl/pcs_rx_block_lock.sv
// 64b/66b receive block-lock FSM: sync-header qualification, gearbox bit-slip and lock tracking.
// Optional high-BER monitor is compiled in when PCS_HIBER_EN is defined; otherwise hi_ber_o is tied 0.
module pcs_rx_block_lock #(
    parameter int LOCK_CNT  = 64,
    parameter int WIN_CNT   = 64,
    parameter int BAD_MAX   = 16,
    parameter int SLIP_WAIT = 4
`ifdef PCS_HIBER_EN
    ,
    parameter int BER_WIN   = 3125,
    parameter int BER_THR   = 16
`endif
) (
    input  logic               TX_CLK,
    input  logic               rstn_as_i,
    pcs_rx_block_lock_if.slave rx
);

    typedef enum logic [1:0] {ST_INIT, ST_HUNT, ST_SLIP, ST_LOCKED} state_t;

    state_t     state_q, state_d;
    logic [6:0] sh_cnt_q, sh_cnt_d, sh_cnt_inc;
    logic [4:0] bad_cnt_q, bad_cnt_d, bad_cnt_inc;
    logic [2:0] wait_cnt_q, wait_cnt_d;
    logic       slip_q, slip_d;
    logic       lock_q, lock_d;
    logic       rxvalid_q, rxvalid_d;
    logic       sgnl_good;

    assign sgnl_good   = (rx.SGNL_OK == 2'b11);
    assign sh_cnt_inc  = sh_cnt_q + 7'd1;
    assign bad_cnt_inc = bad_cnt_q + {4'd0, ~rx.sh_ok_i};

    // Signal loss overrides every transition; wait_cnt defaults to 0 so it only lives in SLIP.
    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        wait_cnt_d = '0;
        slip_d     = 1'b0;
        if (!sgnl_good) begin
            state_d   = ST_INIT;
            sh_cnt_d  = '0;
            bad_cnt_d = '0;
        end else begin
            case (state_q)
                ST_INIT: state_d = ST_HUNT;
                ST_HUNT: begin
                    if (rx.hdr_vld_i) begin
                        if (!rx.sh_ok_i) begin
                            state_d   = ST_SLIP;
                            slip_d    = 1'b1;
                            sh_cnt_d  = '0;
                            bad_cnt_d = '0;
                        end else if (sh_cnt_inc == 7'(LOCK_CNT)) begin
                            state_d   = ST_LOCKED;
                            sh_cnt_d  = '0;
                            bad_cnt_d = '0;
                        end else begin
                            sh_cnt_d  = sh_cnt_inc;
                        end
                    end
                end
                ST_SLIP: begin
                    if (wait_cnt_q == 3'(SLIP_WAIT - 1)) begin
                        state_d   = ST_HUNT;
                        sh_cnt_d  = '0;
                        bad_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 3'd1;
                    end
                end
                ST_LOCKED: begin
                    // Reaching BAD_MAX wins over a simultaneous end-of-window clear.
                    if (rx.hdr_vld_i) begin
                        if (bad_cnt_inc == 5'(BAD_MAX)) begin
                            state_d   = ST_SLIP;
                            slip_d    = 1'b1;
                            sh_cnt_d  = '0;
                            bad_cnt_d = '0;
                        end else if (sh_cnt_inc == 7'(WIN_CNT)) begin
                            sh_cnt_d  = '0;
                            bad_cnt_d = '0;
                        end else begin
                            sh_cnt_d  = sh_cnt_inc;
                            bad_cnt_d = bad_cnt_inc;
                        end
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
        lock_d    = (state_d == ST_LOCKED);
        rxvalid_d = sgnl_good & rx.hdr_vld_i & lock_q;
    end

    always_ff @(posedge TX_CLK or negedge rstn_as_i) begin
        if (!rstn_as_i) begin
            state_q    <= ST_INIT;
            sh_cnt_q   <= '0;
            bad_cnt_q  <= '0;
            wait_cnt_q <= '0;
            slip_q     <= 1'b0;
            lock_q     <= 1'b0;
            rxvalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            slip_q     <= slip_d;
            lock_q     <= lock_d;
            rxvalid_q  <= rxvalid_d;
        end
    end

    assign rx.slip_o  = slip_q;
    assign rx.LOCK    = lock_q;
    assign rx.RXVALID = rxvalid_q;

`ifdef PCS_HIBER_EN
    localparam int TW = $clog2(BER_WIN);
    localparam int CW = $clog2(BER_THR + 1);

    logic [TW-1:0] ber_tmr_q, ber_tmr_d;
    logic [CW-1:0] ber_cnt_q, ber_cnt_d, ber_cnt_inc;
    logic          hi_ber_q, hi_ber_d;
    logic          ber_expire;

    assign ber_expire = (ber_tmr_q == TW'(BER_WIN - 1));

    // The error count saturates at BER_THR so a flagged window keeps hi_ber_o set through expiry.
    always_comb begin
        ber_tmr_d   = '0;
        ber_cnt_d   = '0;
        hi_ber_d    = 1'b0;
        ber_cnt_inc = ber_cnt_q;
        if (lock_q) begin
            if (rx.hdr_vld_i && !rx.sh_ok_i && (ber_cnt_q != CW'(BER_THR)))
                ber_cnt_inc = ber_cnt_q + 1'b1;
            if (ber_cnt_inc == CW'(BER_THR))
                hi_ber_d = 1'b1;
            else if (ber_expire)
                hi_ber_d = 1'b0;
            else
                hi_ber_d = hi_ber_q;
            if (!ber_expire) begin
                ber_tmr_d = ber_tmr_q + 1'b1;
                ber_cnt_d = ber_cnt_inc;
            end
        end
    end

    always_ff @(posedge TX_CLK or negedge rstn_as_i) begin
        if (!rstn_as_i) begin
            ber_tmr_q <= '0;
            ber_cnt_q <= '0;
            hi_ber_q  <= 1'b0;
        end else begin
            ber_tmr_q <= ber_tmr_d;
            ber_cnt_q <= ber_cnt_d;
            hi_ber_q  <= hi_ber_d;
        end
    end

    assign rx.hi_ber_o = hi_ber_q;
`else
    assign rx.hi_ber_o = 1'b0;
`endif

endmodule

// File: tb/tb_pcs_rx_block_lock.sv
// Directed self-checking bench for pcs_rx_block_lock: acquisition, slip, loss of lock,
// window boundary, signal loss, async reset and the optional PCS_HIBER_EN monitor.
module tb_pcs_rx_block_lock;

   logic TX_CLK = 1'b0;
   logic rstn_as_i;
   int   numCompared   = 0;
   int   numMismatched = 0;

`ifdef PCS_HIBER_EN
   localparam logic HIBER_ON = 1'b1;
`else
   localparam logic HIBER_ON = 1'b0;
`endif

   pcs_rx_block_lock_if bus();

   always #5 TX_CLK = ~TX_CLK;

`ifdef PCS_HIBER_EN
   pcs_rx_block_lock #(.BER_WIN(100)) dut (
      .TX_CLK    (TX_CLK),
      .rstn_as_i (rstn_as_i),
      .rx        (bus)
   );
`else
   pcs_rx_block_lock dut (
      .TX_CLK    (TX_CLK),
      .rstn_as_i (rstn_as_i),
      .rx        (bus)
   );
`endif

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      numCompared++;
      if (actual !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 ns after the edge that consumed them.
   task automatic applyStimulus(input logic [1:0] sgnl, input logic hv, input logic ok);
      bus.SGNL_OK   = sgnl;
      bus.hdr_vld_i = hv;
      bus.sh_ok_i   = ok;
      @(posedge TX_CLK);
      #1;
   endtask

   task automatic checkFlags(input string tag, input logic expLock, input logic expSlip);
      checkOutput(tag, {30'd0, bus.LOCK, bus.slip_o}, {30'd0, expLock, expSlip});
   endtask

   // Starting in HUNT with sh_cnt=0: lock must appear exactly after the 64th valid header.
   task automatic acquire(input string tag);
      for (int i = 1; i <= 64; i++) begin
         applyStimulus(2'b11, 1'b1, 1'b1);
         if (i < 64) checkFlags({tag, "_hunt"}, 1'b0, 1'b0);
         else        checkFlags({tag, "_lock"}, 1'b1, 1'b0);
      end
   endtask

   initial begin
      rstn_as_i     = 1'b0;
      bus.SGNL_OK   = 2'b00;
      bus.hdr_vld_i = 1'b0;
      bus.sh_ok_i   = 1'b0;
      #12;
      checkOutput("rst_lock",    bus.LOCK,     1'b0);
      checkOutput("rst_slip",    bus.slip_o,   1'b0);
      checkOutput("rst_rxvalid", bus.RXVALID,  1'b0);
      checkOutput("rst_hiber",   bus.hi_ber_o, 1'b0);
      rstn_as_i = 1'b1;
      applyStimulus(2'b00, 1'b1, 1'b1);
      checkFlags("init_hold", 1'b0, 1'b0);

      $display("[TB] T1 acquisition");
      applyStimulus(2'b11, 1'b0, 1'b0);
      acquire("t1");
      checkOutput("t1_rxvalid_first", bus.RXVALID, 1'b0);

      $display("[TB] T3 loss of lock");
      for (int i = 0; i < 64; i++) begin
         applyStimulus(2'b11, 1'b1, !((i % 4 == 0) && (i < 60)));
         checkFlags("t3_win1", 1'b1, 1'b0);
         if (i == 0) checkOutput("t3_rxvalid", bus.RXVALID, 1'b1);
      end
      for (int i = 1; i <= 40; i++) begin
         applyStimulus(2'b11, 1'b1, (i < 25));
         if (i < 40) checkFlags("t3_win2", 1'b1, 1'b0);
         else        checkFlags("t3_loss", 1'b0, 1'b1);
      end
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(2'b11, 1'b1, 1'b0);
         checkFlags("t3_slip_wait", 1'b0, 1'b0);
      end

      $display("[TB] T2 slip");
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(2'b11, 1'b1, 1'b1);
         checkFlags("t2_hunt", 1'b0, 1'b0);
      end
      applyStimulus(2'b11, 1'b1, 1'b0);
      checkFlags("t2_slip", 1'b0, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(2'b11, 1'b1, 1'b0);
         checkFlags("t2_ignore", 1'b0, 1'b0);
      end
      acquire("t2");

      $display("[TB] T4 window boundary");
      for (int i = 1; i <= 64; i++) begin
         applyStimulus(2'b11, 1'b1, (i <= 48));
         if (i < 64) checkFlags("t4_win", 1'b1, 1'b0);
         else        checkFlags("t4_slip", 1'b0, 1'b1);
      end
      for (int i = 1; i <= 4; i++) applyStimulus(2'b11, 1'b0, 1'b0);
      acquire("t4");
      applyStimulus(2'b11, 1'b0, 1'b1);
      checkOutput("rxvalid_idle", bus.RXVALID, 1'b0);
      applyStimulus(2'b11, 1'b1, 1'b1);
      checkOutput("rxvalid_hdr", bus.RXVALID, 1'b1);

      $display("[TB] T5 signal loss and reset");
      applyStimulus(2'b01, 1'b1, 1'b1);
      checkFlags("t5_sgnl_loss", 1'b0, 1'b0);
      checkOutput("t5_sgnl_rxvalid", bus.RXVALID, 1'b0);
      applyStimulus(2'b11, 1'b1, 1'b1);
      checkFlags("t5_init", 1'b0, 1'b0);
      for (int i = 1; i <= 30; i++) applyStimulus(2'b11, 1'b1, 1'b1);
      #2;
      rstn_as_i = 1'b0;
      #1;
      checkFlags("t5_rst_hunt", 1'b0, 1'b0);
      checkOutput("t5_rst_rxvalid", bus.RXVALID, 1'b0);
      rstn_as_i = 1'b1;
      applyStimulus(2'b11, 1'b0, 1'b0);
      acquire("t5");

      $display("[TB] T6 high BER monitor");
      for (int cyc = 1; cyc <= 200; cyc++) begin
         applyStimulus(2'b11, 1'b1, !((cyc >= 57) && (cyc <= 72)));
         case (cyc)
            71:  checkOutput("t6_hiber_71",  bus.hi_ber_o, 1'b0);
            72:  checkOutput("t6_hiber_72",  bus.hi_ber_o, HIBER_ON);
            100: checkOutput("t6_hiber_100", bus.hi_ber_o, HIBER_ON);
            199: checkOutput("t6_hiber_199", bus.hi_ber_o, HIBER_ON);
            200: checkOutput("t6_hiber_200", bus.hi_ber_o, 1'b0);
            default: ;
         endcase
      end
      checkFlags("t6_still_locked", 1'b1, 1'b0);

      #2;
      rstn_as_i = 1'b0;
      #1;
      checkFlags("rst_locked", 1'b0, 1'b0);
      checkOutput("rst_locked_rxvalid", bus.RXVALID, 1'b0);
      checkOutput("rst_locked_hiber", bus.hi_ber_o, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
